// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the writeback arbiter, the
// register file and decode.
package regfile_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above rr_ptr
// (wrapping) and moves the pointer past the winner when advance is high.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] gidx;
   logic [PTR_W-1:0] ptr_nxt;
   logic             found;

   always_comb begin
      grant = '0;
      gidx  = rr_ptr;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req[(int'(rr_ptr) + k) % N]) begin
            found = 1'b1;
            gidx  = PTR_W'((int'(rr_ptr) + k) % N);
            grant[(int'(rr_ptr) + k) % N] = 1'b1;
         end
      end
      ptr_nxt = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (advance) begin
         rr_ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port among NUM_REQ
// sources and tracks pending destinations. Macro REGFILE_WB_BYPASS_EN adds
// forwarding outputs from the registered write port.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int BIT_SIZE = 32,
   parameter int NUM_REQ  = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*BIT_SIZE-1:0]  req_data,
   input  logic                         wb_en,
   input  logic                         issue_valid,
   input  reg_addr_t                    issue_addr,
   input  reg_addr_t                    rd_addr_1,
   input  reg_addr_t                    rd_addr_2,
   output logic                         busy_1,
   output logic                         busy_2,
`ifdef REGFILE_WB_BYPASS_EN
   output logic                         byp_hit_1,
   output logic                         byp_hit_2,
   output logic [BIT_SIZE-1:0]          byp_data_1,
   output logic [BIT_SIZE-1:0]          byp_data_2,
`endif
   output logic                         RegWrite,
   output reg_addr_t                    Write_addr,
   output logic [BIT_SIZE-1:0]          Write_data
);

   logic [NUM_REQ-1:0]  grant;
   logic                xfer;
   logic                xfer_wr;
   reg_addr_t           sel_addr;
   logic [BIT_SIZE-1:0] sel_data;
   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pending_nxt;
   logic                busy_raw_1;
   logic                busy_raw_2;

   rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .advance (xfer),
      .grant   (grant)
   );

   // Ready is held off during reset so nothing is accepted while flushing.
   assign req_ready = (wb_en && !rst) ? grant : '0;
   assign xfer      = |(req_valid & req_ready);
   assign xfer_wr   = xfer && (sel_addr != '0);

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_addr = req_addr[REG_ADDR_W*i +: REG_ADDR_W];
            sel_data = req_data[BIT_SIZE*i +: BIT_SIZE];
         end
      end
   end

   // Writes to r0 are consumed but never reach the register file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWrite   <= 1'b0;
         Write_addr <= '0;
         Write_data <= '0;
      end else begin
         RegWrite <= xfer_wr;
         if (xfer_wr) begin
            Write_addr <= sel_addr;
            Write_data <= sel_data;
         end
      end
   end

   // Set is applied after clear so a freshly issued producer stays outstanding.
   always_comb begin
      pending_nxt = pending;
      if (xfer_wr) begin
         pending_nxt[sel_addr] = 1'b0;
      end
      if (issue_valid && (issue_addr != '0)) begin
         pending_nxt[issue_addr] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

   assign busy_raw_1 = pending[rd_addr_1];
   assign busy_raw_2 = pending[rd_addr_2];

`ifdef REGFILE_WB_BYPASS_EN
   assign byp_hit_1  = RegWrite && (Write_addr == rd_addr_1) && (rd_addr_1 != '0);
   assign byp_hit_2  = RegWrite && (Write_addr == rd_addr_2) && (rd_addr_2 != '0);
   assign byp_data_1 = Write_data;
   assign byp_data_2 = Write_data;
   assign busy_1     = busy_raw_1 && !byp_hit_1;
   assign busy_2     = busy_raw_2 && !byp_hit_2;
`else
   assign busy_1     = busy_raw_1;
   assign busy_2     = busy_raw_2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NUM_REQ=2): vector table plus
// hand sequences for fairness and reset; covers REGFILE_WB_BYPASS_EN too.
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [9:0]  req_addr;
   logic [63:0] req_data;
   logic        wb_en;
   logic        issue_valid;
   logic [4:0]  issue_addr;
   logic [4:0]  rd_addr_1;
   logic [4:0]  rd_addr_2;
   logic        busy_1;
   logic        busy_2;
   logic        RegWrite;
   logic [4:0]  Write_addr;
   logic [31:0] Write_data;
`ifdef REGFILE_WB_BYPASS_EN
   logic        byp_hit_1;
   logic        byp_hit_2;
   logic [31:0] byp_data_1;
   logic [31:0] byp_data_2;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   regfile_wb_arbiter #(.BIT_SIZE(32), .NUM_REQ(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .wb_en       (wb_en),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .rd_addr_1   (rd_addr_1),
      .rd_addr_2   (rd_addr_2),
      .busy_1      (busy_1),
      .busy_2      (busy_2),
`ifdef REGFILE_WB_BYPASS_EN
      .byp_hit_1   (byp_hit_1),
      .byp_hit_2   (byp_hit_2),
      .byp_data_1  (byp_data_1),
      .byp_data_2  (byp_data_2),
`endif
      .RegWrite    (RegWrite),
      .Write_addr  (Write_addr),
      .Write_data  (Write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  v;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        en;
      logic        iv;
      logic [4:0]  ia;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [1:0]  e_rdy;
      logic        e_b1;
      logic        e_b2;
      logic        e_rw;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
   } vec_t;

   vec_t vecs[13];

   // Bench-side copy of the write-port registers, used for bypass expectations.
   logic        m_rw;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t t);
      req_valid   = t.v;
      req_addr    = {t.a1, t.a0};
      req_data    = {t.d1, t.d0};
      wb_en       = t.en;
      issue_valid = t.iv;
      issue_addr  = t.ia;
      rd_addr_1   = t.r1;
      rd_addr_2   = t.r2;
   endtask

   task automatic check_busy(input string tag, input logic b1, input logic b2);
      logic h1, h2;
      h1 = 1'b0;
      h2 = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
      h1 = m_rw && (m_wa == rd_addr_1) && (rd_addr_1 != 5'd0);
      h2 = m_rw && (m_wa == rd_addr_2) && (rd_addr_2 != 5'd0);
      check({tag, " byp_hit_1"}, 32'(byp_hit_1), 32'(h1));
      check({tag, " byp_hit_2"}, 32'(byp_hit_2), 32'(h2));
      if (h1) check({tag, " byp_data_1"}, byp_data_1, m_wd);
      if (h2) check({tag, " byp_data_2"}, byp_data_2, m_wd);
`endif
      check({tag, " busy_1"}, 32'(busy_1), 32'(b1 && !h1));
      check({tag, " busy_2"}, 32'(busy_2), 32'(b2 && !h2));
   endtask

   initial begin
      //            v     a0    a1    d0            d1        en   iv   ia    r1    r2   rdy   b1   b2   rw   wa    wd
      vecs[0]  = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,    1'b1,1'b0,5'd0, 5'd5, 5'd0,2'b01,1'b0,1'b0,1'b1,5'd5, 32'hDEADBEEF};
      vecs[1]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b1,1'b1,5'd7, 5'd7, 5'd5,2'b00,1'b0,1'b0,1'b0,5'd5, 32'hDEADBEEF};
      vecs[2]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b1,1'b1,5'd9, 5'd7, 5'd9,2'b00,1'b1,1'b0,1'b0,5'd5, 32'hDEADBEEF};
      vecs[3]  = '{2'b11, 5'd7, 5'd9, 32'h11,       32'h22,   1'b1,1'b0,5'd0, 5'd7, 5'd9,2'b10,1'b1,1'b1,1'b1,5'd9, 32'h22};
      vecs[4]  = '{2'b01, 5'd7, 5'd0, 32'h11,       32'h0,    1'b1,1'b0,5'd0, 5'd7, 5'd9,2'b01,1'b1,1'b0,1'b1,5'd7, 32'h11};
      vecs[5]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b1,1'b0,5'd0, 5'd7, 5'd9,2'b00,1'b0,1'b0,1'b0,5'd7, 32'h11};
      vecs[6]  = '{2'b11, 5'd3, 5'd4, 32'h33,       32'h44,   1'b0,1'b0,5'd0, 5'd3, 5'd4,2'b00,1'b0,1'b0,1'b0,5'd7, 32'h11};
      vecs[7]  = '{2'b11, 5'd3, 5'd4, 32'h33,       32'h44,   1'b1,1'b0,5'd0, 5'd3, 5'd4,2'b10,1'b0,1'b0,1'b1,5'd4, 32'h44};
      vecs[8]  = '{2'b01, 5'd3, 5'd0, 32'h33,       32'h0,    1'b1,1'b0,5'd0, 5'd3, 5'd4,2'b01,1'b0,1'b0,1'b1,5'd3, 32'h33};
      vecs[9]  = '{2'b10, 5'd0, 5'd0, 32'h0,        32'h55,   1'b1,1'b0,5'd0, 5'd0, 5'd3,2'b10,1'b0,1'b0,1'b0,5'd3, 32'h33};
      vecs[10] = '{2'b11, 5'd6, 5'd8, 32'h66,       32'h88,   1'b1,1'b0,5'd0, 5'd6, 5'd8,2'b01,1'b0,1'b0,1'b1,5'd6, 32'h66};
      vecs[11] = '{2'b10, 5'd0, 5'd8, 32'h0,        32'h88,   1'b1,1'b1,5'd8, 5'd8, 5'd6,2'b10,1'b0,1'b0,1'b1,5'd8, 32'h88};
      vecs[12] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,    1'b1,1'b0,5'd0, 5'd8, 5'd0,2'b00,1'b1,1'b0,1'b0,5'd8, 32'h88};

      rst = 1'b1;
      req_valid = 2'b00; req_addr = '0; req_data = '0; wb_en = 1'b1;
      issue_valid = 1'b0; issue_addr = '0; rd_addr_1 = '0; rd_addr_2 = '0;
      m_rw = 1'b0; m_wa = '0; m_wd = '0;

      #12;
      req_valid = 2'b11;
      #1;
      check("reset RegWrite", 32'(RegWrite), 32'h0);
      check("reset Write_addr", 32'(Write_addr), 32'h0);
      check("reset Write_data", Write_data, 32'h0);
      check("reset req_ready", 32'(req_ready), 32'h0);
      req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
         check_busy($sformatf("v%0d", i), vecs[i].e_b1, vecs[i].e_b2);
         @(posedge clk);
         #1;
         check($sformatf("v%0d RegWrite", i), 32'(RegWrite), 32'(vecs[i].e_rw));
         check($sformatf("v%0d Write_addr", i), 32'(Write_addr), 32'(vecs[i].e_wa));
         check($sformatf("v%0d Write_data", i), Write_data, vecs[i].e_wd);
         m_rw = vecs[i].e_rw;
         m_wa = vecs[i].e_wa;
         m_wd = vecs[i].e_wd;
      end

      // Fairness: both requesters continuously valid, pointer starts at 0.
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_valid = 2'b11; wb_en = 1'b1; issue_valid = 1'b0;
         req_addr = {5'd11, 5'd10};
         req_data = {32'(32'hB00 + c), 32'(32'hA00 + c)};
         #1;
         check($sformatf("fair%0d req_ready", c), 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
         @(posedge clk);
         #1;
         check($sformatf("fair%0d Write_addr", c), 32'(Write_addr), (c % 2 == 0) ? 32'd10 : 32'd11);
         check($sformatf("fair%0d Write_data", c), Write_data,
               (c % 2 == 0) ? 32'(32'hA00 + c) : 32'(32'hB00 + c));
      end

      // Reset mid-operation with r1, r2 pending and a write in flight.
      @(negedge clk);
      req_valid = 2'b00; issue_valid = 1'b1; issue_addr = 5'd1;
      @(negedge clk);
      issue_addr = 5'd2;
      @(negedge clk);
      issue_valid = 1'b0;
      req_valid = 2'b01; req_addr = {5'd0, 5'd5}; req_data = {32'h0, 32'h0000ABCD};
      rd_addr_1 = 5'd1; rd_addr_2 = 5'd2;
      @(posedge clk);
      #1;
      req_valid = 2'b11;
      check("prerst RegWrite", 32'(RegWrite), 32'h1);
      check("prerst busy_1", 32'(busy_1), 32'h1);
      check("prerst busy_2", 32'(busy_2), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("midrst RegWrite", 32'(RegWrite), 32'h0);
      check("midrst Write_addr", 32'(Write_addr), 32'h0);
      check("midrst Write_data", Write_data, 32'h0);
      check("midrst busy_1", 32'(busy_1), 32'h0);
      check("midrst busy_2", 32'(busy_2), 32'h0);
      check("midrst req_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("postrst req_ready", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;
      check("postrst Write_addr", 32'(Write_addr), 32'd5);
      req_valid = 2'b00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
